// File: rtl/busca_instrucao.sv
// busca_instrucao -- instruction fetch stage of the 8-bit NRISC core.
//
// Holds the PC, reads one instruction byte per fetch from instruction memory
// over a req/ack interface, latches it into MemInstruc for the control unit
// (unidadecontrole) and offers it downstream with a valid/ready handshake.
// Branch redirect (desvio) and halt are applied when the byte is consumed.
//
// Optional feature macro: BUSCA_WATCHDOG_EN
//   defined   -> a fetch that waits TIMEOUT cycles without mem_ack sets
//                erro_busca and parks the stage in PARADO until reset.
//   undefined -> no watchdog; erro_busca is tied low; fetch waits forever.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   mem_addr     instruction-memory address (always equals pc)
//   mem_req      read request, held until mem_ack
//   mem_ack      read complete, mem_data valid this cycle
//   mem_data     instruction byte from memory
//   MemInstruc   latched instruction to the control unit
//   instr_valid  MemInstruc is valid
//   instr_ready  downstream consumes MemInstruc
//   desvio       branch taken (sampled at handshake)
//   desvio_alvo  branch target (sampled at handshake)
//   halt         halt request (sampled at handshake, wins over desvio)
//   pc           address of the next fetch
//   parado       core halted
//   erro_busca   fetch timeout flag
module busca_instrucao #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_req,
    input  logic            mem_ack,
    input  logic [7:0]      mem_data,
    output logic [7:0]      MemInstruc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            desvio,
    input  logic [PC_W-1:0] desvio_alvo,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            parado,
    output logic            erro_busca
);

    typedef enum logic [1:0] {
        BUSCA   = 2'b00,
        ENTREGA = 2'b01,
        PARADO  = 2'b10
    } estado_t;

    estado_t         r_estado;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_instr;
    logic            r_req;
    logic            r_valid;
    logic            r_parado;

`ifdef BUSCA_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Terminal count is TIMEOUT-1 so the trip happens on the TIMEOUT-th
    // waiting cycle.
    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_erro;
`endif

    // Fetch/deliver state machine with all outputs held in registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= BUSCA;
            r_pc     <= PC_W'(RESET_PC);
            r_instr  <= 8'h00;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_parado <= 1'b0;
`ifdef BUSCA_WATCHDOG_EN
            r_cnt    <= '0;
            r_erro   <= 1'b0;
`endif
        end else begin
            case (r_estado)
                BUSCA: begin
                    // An ack is accepted even before mem_req rises, so a
                    // stale ack right after reset becomes the RESET_PC fetch.
                    if (mem_ack) begin
                        r_instr  <= mem_data;
                        r_pc     <= r_pc + PC_W'(1);
                        r_req    <= 1'b0;
                        r_valid  <= 1'b1;
                        r_estado <= ENTREGA;
`ifdef BUSCA_WATCHDOG_EN
                        r_cnt    <= '0;
                    end else if (r_cnt == LIMITE) begin
                        r_erro   <= 1'b1;
                        r_parado <= 1'b1;
                        r_req    <= 1'b0;
                        r_estado <= PARADO;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_req    <= 1'b1;
`else
                    end else begin
                        r_req    <= 1'b1;
`endif
                    end
                end
                ENTREGA: begin
                    // r_valid is 1 throughout ENTREGA, so ready alone
                    // marks the handshake.
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        if (halt) begin
                            r_parado <= 1'b1;
                            r_estado <= PARADO;
                        end else begin
                            if (desvio) begin
                                r_pc <= desvio_alvo;
                            end else begin
                                r_pc <= r_pc;
                            end
                            r_req    <= 1'b1;
                            r_estado <= BUSCA;
`ifdef BUSCA_WATCHDOG_EN
                            r_cnt    <= '0;
`endif
                        end
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                PARADO: begin
                    r_req    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_parado <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely until reset.
                    r_req    <= 1'b0;
                    r_valid  <= 1'b0;
                    r_parado <= 1'b1;
                    r_estado <= PARADO;
                end
            endcase
        end
    end

    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign mem_req     = r_req;
    assign MemInstruc  = r_instr;
    assign instr_valid = r_valid;
    assign parado      = r_parado;
`ifdef BUSCA_WATCHDOG_EN
    assign erro_busca  = r_erro;
`else
    assign erro_busca  = 1'b0;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: a table of fetch records, a
// randomized run checked against a simple PC model, and hand-written
// sequences for halt, asynchronous reset and the fetch watchdog.
module tb_busca_instrucao;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] MemInstruc;
    logic       instr_valid;
    logic       instr_ready;
    logic       desvio;
    logic [7:0] desvio_alvo;
    logic       halt;
    logic [7:0] pc;
    logic       parado;
    logic       erro_busca;

    int total = 0;
    int bad   = 0;

    // Reference model state: address of the next fetch.
    logic [7:0] m_pc;

    typedef struct {
        logic [7:0] data;
        int         ack_dly;
        int         rdy_dly;
        logic       dsv;
        logic [7:0] alvo;
        logic       hlt;
    } vec_t;

    vec_t tbl [8];

    busca_instrucao #(.PC_W(8), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .MemInstruc  (MemInstruc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .desvio      (desvio),
        .desvio_alvo (desvio_alvo),
        .halt        (halt),
        .pc          (pc),
        .parado      (parado),
        .erro_busca  (erro_busca)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
        desvio = 1'b0; halt = 1'b0;
        @(negedge clock);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", MemInstruc, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_parado", parado, 1'b0);
        chk("rst_erro", erro_busca, 1'b0);
        reset = 1'b0;
        m_pc = 8'h00;
    endtask

    // One full instruction: request, ack after ack_dly cycles, backpressure
    // for rdy_dly cycles (with ignored noise on ack/desvio/halt), handshake.
    task automatic run_vec(input vec_t v);
        int k;
        logic [7:0] fetch_addr;
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("req_timeout", mem_req, 1'b1);
        fetch_addr = m_pc;
        chk("fetch_addr", mem_addr, fetch_addr);
        for (int i = 0; i < v.ack_dly; i++) begin
            @(negedge clock);
            chk("req_hold", mem_req, 1'b1);
            chk("addr_hold", mem_addr, fetch_addr);
        end
        mem_ack = 1'b1; mem_data = v.data;
        @(negedge clock);
        mem_ack = 1'b0; mem_data = 8'($urandom);
        m_pc = fetch_addr + 8'd1;
        chk("valid_after_ack", instr_valid, 1'b1);
        chk("instr", MemInstruc, v.data);
        chk("pc_after_ack", pc, m_pc);
        chk("req_low_entrega", mem_req, 1'b0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            instr_ready = 1'b0;
            desvio = 1'($urandom); halt = 1'($urandom);
            desvio_alvo = 8'($urandom);
            mem_ack = 1'($urandom); mem_data = 8'($urandom);
            @(negedge clock);
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_instr", MemInstruc, v.data);
            chk("bp_req", mem_req, 1'b0);
            chk("bp_pc", pc, m_pc);
        end
        mem_ack = 1'b0;
        instr_ready = 1'b1; desvio = v.dsv; desvio_alvo = v.alvo; halt = v.hlt;
        @(negedge clock);
        instr_ready = 1'b0; desvio = 1'b0; halt = 1'b0;
        if (v.hlt) begin
            chk("halt_parado", parado, 1'b1);
            chk("halt_req", mem_req, 1'b0);
            chk("halt_valid", instr_valid, 1'b0);
            chk("halt_pc", pc, m_pc);
        end else begin
            if (v.dsv) m_pc = v.alvo;
            chk("next_req", mem_req, 1'b1);
            chk("next_addr", mem_addr, m_pc);
            chk("next_valid", instr_valid, 1'b0);
            chk("next_parado", parado, 1'b0);
        end
    endtask

    initial begin
        vec_t       v;
        logic [7:0] held_instr;

        reset = 1'b1; mem_ack = 1'b0; mem_data = 8'h00; instr_ready = 1'b0;
        desvio = 1'b0; desvio_alvo = 8'h00; halt = 1'b0; m_pc = 8'h00;

        tbl[0] = '{data: 8'h21, ack_dly: 1, rdy_dly: 0, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};
        tbl[1] = '{data: 8'h05, ack_dly: 1, rdy_dly: 0, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};
        tbl[2] = '{data: 8'hC3, ack_dly: 1, rdy_dly: 0, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};
        tbl[3] = '{data: 8'h7A, ack_dly: 0, rdy_dly: 4, dsv: 1'b1, alvo: 8'h40, hlt: 1'b0};
        tbl[4] = '{data: 8'h11, ack_dly: 2, rdy_dly: 1, dsv: 1'b1, alvo: 8'hFF, hlt: 1'b0};
        tbl[5] = '{data: 8'h99, ack_dly: 0, rdy_dly: 0, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};
        tbl[6] = '{data: 8'h3C, ack_dly: 3, rdy_dly: 2, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};
        tbl[7] = '{data: 8'hE4, ack_dly: 1, rdy_dly: 0, dsv: 1'b0, alvo: 8'h00, hlt: 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            if (i == 2) chk("pc_after_three", pc, 8'h03);
        end

        // Randomized run against the PC model.
        for (int i = 0; i < 30; i++) begin
            v.data    = 8'($urandom);
            v.ack_dly = int'($urandom_range(0, 3));
            v.rdy_dly = int'($urandom_range(0, 3));
            v.dsv     = ($urandom_range(0, 3) == 0);
            v.alvo    = 8'($urandom);
            v.hlt     = 1'b0;
            run_vec(v);
        end

        // Halt together with a branch: halt wins, pc keeps its value.
        v = '{data: 8'h5A, ack_dly: 1, rdy_dly: 1, dsv: 1'b1, alvo: 8'h40, hlt: 1'b1};
        run_vec(v);
        held_instr = MemInstruc;
        chk("halted_instr", held_instr, 8'h5A);
        mem_ack = 1'b1; mem_data = 8'hEE;
        @(negedge clock);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("halted_stay", parado, 1'b1);
            chk("halted_req", mem_req, 1'b0);
            chk("halted_valid", instr_valid, 1'b0);
            chk("halted_pc", pc, m_pc);
            chk("halted_instr_hold", MemInstruc, 8'h5A);
        end

        // Reset asserted mid-fetch at pc 8'h10 takes effect without a clock.
        do_reset();
        v = '{data: 8'h77, ack_dly: 0, rdy_dly: 0, dsv: 1'b1, alvo: 8'h10, hlt: 1'b0};
        run_vec(v);
        chk("pre_rst_addr", mem_addr, 8'h10);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 8'h00);
        chk("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_instr", MemInstruc, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        m_pc = 8'h00;

        // Memory never answers.
        repeat (20) @(negedge clock);
`ifdef BUSCA_WATCHDOG_EN
        chk("wd_erro", erro_busca, 1'b1);
        chk("wd_parado", parado, 1'b1);
        chk("wd_req", mem_req, 1'b0);
`else
        chk("nowd_erro", erro_busca, 1'b0);
        chk("nowd_req", mem_req, 1'b1);
        chk("nowd_parado", parado, 1'b0);
        chk("nowd_addr", mem_addr, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
